count_seg_display: RTL and testbench
====================================

// Module: count_seg_display
// PURPOSE
//   Downstream consumer of the 4-bit mod-16 up counter. Shows the count value 0..15
//   as two decimal digits on a multiplexed 7-segment display.
//   Tears-free: the count is snapshotted once per refresh frame.
//   Also flags counter wrap-around (15->0) with a one-cycle pulse for later stages.
// PARAMETERS
//   REFRESH_DIV     100000  clk cycles each digit is lit per slot; legal range >= 2
//   BLANK_CYCLES    16      dead cycles with all digits off between slots (anti-ghosting); >= 1
//   SEG_ACTIVE_LOW  1       1: seg outputs active-low; 0: active-high
// PORTS
//   clk         in   1  system clock, all logic on rising edge
//   reset       in   1  asynchronous, active-high; clears all state
//   count       in   4  counter value, synchronous to clk
//   seg         out  7  segment drive {g,f,e,d,c,b,a}, seg[0]=a, polarity per SEG_ACTIVE_LOW
//   an          out  2  digit enables, active-low; an[0]=ones, an[1]=tens
//   wrap_pulse  out  1  high for exactly one cycle when count goes 15 -> 0
// BEHAVIOUR
//   Reset values (async, immediate):
//     - an=2'b11, seg=all segments off (7'h7F if SEG_ACTIVE_LOW else 7'h00), wrap_pulse=0
//     - state=S_GAP0, div_cnt=0, snap=0, prev_count=0
//   FSM: S_GAP0 -> S_ONES -> S_GAP1 -> S_TENS -> S_GAP0 ...
//     - GAP states last BLANK_CYCLES cycles; ONES/TENS last REFRESH_DIV cycles
//     - div_cnt counts 0..N-1 within a state; at N-1 it returns to 0 and the state advances
//     - Frame length = 2*(REFRESH_DIV+BLANK_CYCLES) cycles
//   Snapshot: on the S_GAP0 -> S_ONES transition edge, snap <= count
//     - count changes mid-frame do not affect the frame in progress
//     - worst-case display latency is one full frame plus one cycle
//   Digit split: tens = (snap >= 10); ones = snap - (tens ? 10 : 0), 4-bit arithmetic, ones 0..9
//   Encoding (active-high form, before polarity):
//     0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   Outputs are registered; value reflects the state being entered (no extra cycle of lag):
//     - S_ONES: an=2'b10, seg=enc(ones)
//     - S_TENS with tens=1: an=2'b01, seg=enc(1)
//     - S_TENS with tens=0: leading-zero blank, an=2'b11, seg=off
//     - GAP states: an=2'b11, seg=off
//     - Both digits are never enabled simultaneously, in any cycle
//   Wrap detect: prev_count <= count every cycle
//     - wrap_pulse <= (prev_count==4'd15 && count==4'd0), registered, 1-cycle latency
//     - Sustained count=0 yields one pulse only
//     - Any other jump (e.g. 15->3) gives no pulse
//     - Reset clears prev_count, so a reset-driven 15->0 yields no pulse
//   Reset mid-frame: outputs blank at once; on release, restart from S_GAP0, div_cnt=0
//   div_cnt width = $clog2(max(REFRESH_DIV,BLANK_CYCLES)); no overflow possible
// STRUCTURE
//   Package count_display_pkg:
//     - state enum {S_GAP0,S_ONES,S_GAP1,S_TENS}
//     - SEG_OFF constant, digit encoding localparams
//   Sub-module seg7_decoder: combinational 4-bit digit -> 7-bit active-high pattern;
//     polarity applied in count_seg_display
//   Top holds FSM, prescaler, snapshot, split, output registers, wrap detector
// TESTING (bench params REFRESH_DIV=4, BLANK_CYCLES=2, SEG_ACTIVE_LOW=1)
//   1. Reset held 5 cycles, count=7 -> an=11, seg=7F, wrap_pulse=0 throughout
//      After release: 2 blank cycles, then an=10, seg=~07 for 4 cycles
//   2. count=13 steady -> ones slot seg=~4F (digit 3), tens slot an=01, seg=~06
//      Frame period exactly 12 cycles
//   3. count=5 -> tens slot: an=11, seg=7F (leading-zero blank); ones slot shows ~6D
//   4. count 15 -> 0 held -> wrap_pulse=1 for exactly one cycle, one clk after count=0
//      count 15 -> 3 -> no pulse
//   5. count 2 -> 9 in the 2nd cycle of the ones slot -> that frame shows 2;
//      next frame shows 9 (~6F)
//   6. Reset asserted in the tens slot with count=12 -> an=11 same cycle
//      After release: sequence restarts at S_GAP0
//      Check every cycle: an != 2'b00

Source files
------------

// File: rtl/count_display_pkg.sv
// count_display_pkg
//   Shared types and constants for the count 7-segment display block.
//   - state_t      : display multiplex FSM states
//   - SEG_OFF      : all-segments-off pattern in active-high form
//   - ENC_0..ENC_9 : active-high {g,f,e,d,c,b,a} digit patterns
//   - AN_*         : active-low digit enable codes
//   - apply_polarity converts an active-high pattern to the output polarity
package count_display_pkg;

    typedef enum logic [1:0] {
        S_GAP0 = 2'd0,
        S_ONES = 2'd1,
        S_GAP1 = 2'd2,
        S_TENS = 2'd3
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] ENC_0 = 7'h3F;
    localparam logic [6:0] ENC_1 = 7'h06;
    localparam logic [6:0] ENC_2 = 7'h5B;
    localparam logic [6:0] ENC_3 = 7'h4F;
    localparam logic [6:0] ENC_4 = 7'h66;
    localparam logic [6:0] ENC_5 = 7'h6D;
    localparam logic [6:0] ENC_6 = 7'h7D;
    localparam logic [6:0] ENC_7 = 7'h07;
    localparam logic [6:0] ENC_8 = 7'h7F;
    localparam logic [6:0] ENC_9 = 7'h6F;

    localparam logic [1:0] AN_NONE = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    function automatic logic [6:0] apply_polarity(input logic [6:0] pattern,
                                                  input bit        active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
//   Combinational decimal digit to 7-segment pattern, active-high.
//   Codes 10..15 never occur in this design and decode to blank.
//   Ports:
//     digit    in  4  digit value 0..9
//     pattern  out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module seg7_decoder
    import count_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (digit)
            4'd0: pattern = ENC_0;
            4'd1: pattern = ENC_1;
            4'd2: pattern = ENC_2;
            4'd3: pattern = ENC_3;
            4'd4: pattern = ENC_4;
            4'd5: pattern = ENC_5;
            4'd6: pattern = ENC_6;
            4'd7: pattern = ENC_7;
            4'd8: pattern = ENC_8;
            4'd9: pattern = ENC_9;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/count_seg_display.sv
// count_seg_display
//   Shows a 4-bit count (0..15) as two decimal digits on a two-digit
//   multiplexed 7-segment display, with blank gaps between digit slots,
//   and flags 15 -> 0 wrap-around of the count with a one-cycle pulse.
//   Ports:
//     clk         in   1  system clock, rising edge
//     reset       in   1  asynchronous active-high reset
//     count       in   4  counter value, synchronous to clk
//     seg         out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//     an          out  2  digit enables, active-low; an[0]=ones, an[1]=tens
//     wrap_pulse  out  1  one-cycle pulse when count goes 15 -> 0
//
//   state  | meaning
//   S_GAP0 | all digits off, BLANK_CYCLES; count snapshotted on exit
//   S_ONES | ones digit lit, REFRESH_DIV cycles
//   S_GAP1 | all digits off, BLANK_CYCLES
//   S_TENS | tens digit lit (or blank for leading zero), REFRESH_DIV cycles
module count_seg_display
    import count_display_pkg::*;
#(
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap_pulse
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0]       SEG_BLANK  = apply_polarity(SEG_OFF, SEG_ACTIVE_LOW);

    state_t           state, state_next;
    logic [CNT_W-1:0] div_cnt, div_cnt_next;
    logic             slot_done;
    logic [3:0]       snap, snap_next;
    logic [3:0]       prev_count;
    logic             tens;
    logic [3:0]       ones;
    logic [3:0]       digit;
    logic [6:0]       pattern;
    logic [6:0]       pattern_next;
    logic [1:0]       an_next;
    logic             wrap_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_GAP0;
            div_cnt <= '0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        slot_done    = 1'b0;
        div_cnt_next = div_cnt + 1'b1;

        if (state == S_ONES || state == S_TENS)
            slot_done = (div_cnt == DIV_LAST);
        else
            slot_done = (div_cnt == BLANK_LAST);

        if (slot_done) begin
            div_cnt_next = '0;
            case (state)
                S_GAP0:  state_next = S_ONES;
                S_ONES:  state_next = S_GAP1;
                S_GAP1:  state_next = S_TENS;
                S_TENS:  state_next = S_GAP0;
                default: state_next = S_GAP0;
            endcase
        end
    end

    // Outputs are computed from the state being entered, and the digit split
    // uses the snapshot value being loaded this edge, so the ones digit is
    // already correct in the first cycle of S_ONES.
    always_comb begin
        snap_next = (state == S_GAP0 && slot_done) ? count : snap;
        tens      = (snap_next >= 4'd10);
        ones      = snap_next - (tens ? 4'd10 : 4'd0);
        digit     = (state_next == S_TENS) ? 4'd1 : ones;
    end

    seg7_decoder u_decoder (
        .digit   (digit),
        .pattern (pattern)
    );

    always_comb begin
        an_next      = AN_NONE;
        pattern_next = SEG_OFF;
        case (state_next)
            S_ONES: begin
                an_next      = AN_ONES;
                pattern_next = pattern;
            end
            S_TENS: begin
                if (tens) begin
                    an_next      = AN_TENS;
                    pattern_next = pattern;
                end
            end
            default: begin
                an_next      = AN_NONE;
                pattern_next = SEG_OFF;
            end
        endcase
    end

    assign wrap_next = (prev_count == 4'd15) && (count == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap       <= '0;
            prev_count <= '0;
            an         <= AN_NONE;
            seg        <= SEG_BLANK;
            wrap_pulse <= 1'b0;
        end else begin
            snap       <= snap_next;
            prev_count <= count;
            an         <= an_next;
            seg        <= apply_polarity(pattern_next, SEG_ACTIVE_LOW);
            wrap_pulse <= wrap_next;
        end
    end

endmodule

// File: tb/tb_count_seg_display.sv
module tb_count_seg_display;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap_pulse;

    int n_pass    = 0;
    int n_total   = 0;
    int both_on   = 0;

    // active-low segment patterns for the bench parameters
    localparam logic [6:0] OFF  = 7'h7F;
    localparam logic [6:0] D1   = 7'h79;
    localparam logic [6:0] D2   = 7'h24;
    localparam logic [6:0] D3   = 7'h30;
    localparam logic [6:0] D5   = 7'h12;
    localparam logic [6:0] D7   = 7'h78;
    localparam logic [6:0] D9   = 7'h10;

    count_seg_display #(
        .REFRESH_DIV    (4),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .seg        (seg),
        .an         (an),
        .wrap_pulse (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (an === 2'b00) both_on++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // n cycles, checked at each falling edge
    task automatic slot(input string tag, input logic [1:0] an_exp,
                        input logic [6:0] seg_exp, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_an"}, {6'd0, an}, {6'd0, an_exp});
            chk({tag, "_seg"}, {1'b0, seg}, {1'b0, seg_exp});
        end
    endtask

    task automatic wrap_chk(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, {7'd0, wrap_pulse}, {7'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        count = 4'd7;

        // 1: reset held 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_an", {6'd0, an}, 8'h03);
            chk("rst_seg", {1'b0, seg}, {1'b0, OFF});
            chk("rst_wrap", {7'd0, wrap_pulse}, 8'h00);
        end
        reset = 1'b0;

        slot("f1_gap0", 2'b11, OFF, 1);
        slot("f1_ones7", 2'b10, D7, 4);
        count = 4'd13;
        slot("f1_gap1", 2'b11, OFF, 2);
        slot("f1_tens0", 2'b11, OFF, 4);
        slot("f1_gap0b", 2'b11, OFF, 2);

        // 2: count=13, 12-cycle frame
        slot("f2_ones3", 2'b10, D3, 4);
        count = 4'd5;
        slot("f2_gap1", 2'b11, OFF, 2);
        slot("f2_tens1", 2'b01, D1, 4);
        slot("f2_gap0", 2'b11, OFF, 2);

        // 3: count=5, leading-zero blank
        slot("f3_ones5", 2'b10, D5, 4);
        slot("f3_gap1", 2'b11, OFF, 2);
        count = 4'd2;
        slot("f3_tens_blank", 2'b11, OFF, 4);
        slot("f3_gap0", 2'b11, OFF, 2);

        // 5: count changes to 9 during the ones slot, frame keeps 2
        slot("f4_ones2_first", 2'b10, D2, 1);
        count = 4'd9;
        slot("f4_ones2_rest", 2'b10, D2, 3);
        slot("f4_gap1", 2'b11, OFF, 2);
        slot("f4_tens_blank", 2'b11, OFF, 4);
        slot("f4_gap0", 2'b11, OFF, 2);
        slot("f5_ones9", 2'b10, D9, 4);

        // 4: wrap detection
        count = 4'd15;
        wrap_chk("wrap_hold15", 1'b0);
        wrap_chk("wrap_hold15b", 1'b0);
        count = 4'd0;
        #1 chk("wrap_before_edge", {7'd0, wrap_pulse}, 8'h00);
        wrap_chk("wrap_pulse", 1'b1);
        wrap_chk("wrap_sustain0", 1'b0);
        wrap_chk("wrap_sustain1", 1'b0);
        wrap_chk("wrap_sustain2", 1'b0);
        count = 4'd15;
        wrap_chk("jump_hold15", 1'b0);
        count = 4'd3;
        wrap_chk("jump_15_3", 1'b0);
        wrap_chk("jump_15_3b", 1'b0);

        // reset-driven 15 -> 0 gives no pulse
        count = 4'd15;
        wrap_chk("rstwrap_hold15", 1'b0);
        #1 reset = 1'b1;
        count = 4'd0;
        wrap_chk("rstwrap_in_reset", 1'b0);
        reset = 1'b0;
        wrap_chk("rstwrap_after0", 1'b0);
        wrap_chk("rstwrap_after1", 1'b0);

        // 6: reset in the tens slot with count=12
        count = 4'd12;
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        slot("f6_gap0", 2'b11, OFF, 1);
        slot("f6_ones2", 2'b10, D2, 4);
        slot("f6_gap1", 2'b11, OFF, 2);
        slot("f6_tens1", 2'b01, D1, 2);
        #2 reset = 1'b1;
        #1;
        chk("midrst_an", {6'd0, an}, 8'h03);
        chk("midrst_seg", {1'b0, seg}, {1'b0, OFF});
        @(negedge clk);
        reset = 1'b0;
        slot("f7_gap0", 2'b11, OFF, 1);
        slot("f7_ones2", 2'b10, D2, 4);
        slot("f7_gap1", 2'b11, OFF, 2);
        slot("f7_tens1", 2'b01, D1, 4);

        chk("never_both_on", both_on[7:0], 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
